spi_sram_cache: RTL and testbench
=================================

Name: spi_sram_cache

Overview:
- Wishbone slave/master bridge between the SERV data bus and the SPI SRAM controller.
- Provides a small direct-mapped, write-through, write-allocate word cache, so repeated reads skip the ~58-cycle SPI transfer.
- Converts byte-masked writes into full 32-bit read-modify-write transactions, because the SPI SRAM controller ignores sel and always writes whole words.

Parameters:
- LINES, 8, number of one-word cache lines; power of 2, range 2..64.
- IDX_W, $clog2(LINES), index width (derived, not overridable).
- TAG_W, 14-IDX_W, tag width (derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  invalidate all lines; honoured only in S_IDLE
- cyc  in  1  upstream cycle valid; held until ack
- adr  in  14  upstream word address
- we  in  1  upstream write enable
- dat_i  in  32  upstream write data
- sel  in  4  upstream byte enables; bit n = dat_i[8n+7:8n]
- dat_o  out  32  upstream read data, valid while ack=1
- ack  out  1  upstream acknowledge, one-cycle pulse
- mem_cyc  out  1  downstream cycle valid
- mem_adr  out  14  downstream word address
- mem_we  out  1  downstream write enable
- mem_dat_o  out  32  downstream write data
- mem_dat_i  in  32  downstream read data, valid with mem_ack
- mem_ack  in  1  downstream acknowledge

Behaviour:
- Storage:
  - Per line: valid bit, TAG_W tag, 32-bit data.
  - Only valid bits are reset; tag and data arrays are not reset.
  - Index = adr[IDX_W-1:0]; tag = adr[13:IDX_W].
- Reset (async, rst_n=0): state=S_IDLE, all valid=0, ack=0, mem_cyc=0, mem_we=0, dat_o=0, request registers=0. A reset asserted mid-transaction aborts it and issues no ack.
- S_IDLE:
  - If flush=1: clear all valid bits this cycle, ignore cyc, stay in S_IDLE.
  - Else if cyc=1: latch adr, we, dat_i, sel into request registers; go to S_LOOKUP.
- S_LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Read hit: dat_o<=line data; go to S_ACK.
  - Read miss: go to S_MEM_RD.
  - Write with sel=4'hF: merged=req_dat; go to S_MEM_WR.
  - Partial write, hit: merged = per-byte mux(sel ? req_dat : line data); go to S_MEM_WR.
  - Partial write, miss: go to S_MEM_RD.
  - sel=4'h0 write: acked without memory traffic; go to S_ACK. The cache is unchanged.
- S_MEM_RD:
  - mem_cyc=1, mem_we=0, mem_adr=req_adr.
  - On mem_ack: fill the line (valid=1, tag, mem_dat_i).
    - Read: dat_o<=mem_dat_i; go to S_ACK.
    - Write: merged = mux(sel ? req_dat : mem_dat_i); go to S_MEM_WR.
- S_MEM_WR:
  - mem_cyc=1, mem_we=1, mem_dat_o=merged.
  - On mem_ack: line<=merged (valid=1, tag); go to S_ACK.
- S_ACK: ack=1 for exactly one cycle; go to S_IDLE.
- Outputs:
  - mem_cyc and mem_we are decoded from the state; mem_adr and mem_dat_o come from registers.
  - All mem_* outputs stay stable while mem_cyc=1.
  - mem_cyc drops in the cycle after the final mem_ack. The one exception is the S_MEM_RD→S_MEM_WR transition, where mem_cyc stays high and mem_we rises, which starts a new downstream transaction.
- Latency, counted from the first cycle cyc=1 is sampled in S_IDLE:
  - Read hit: ack 2 cycles later.
  - Read miss: 1 + memory latency + 1.
  - Full write: same as read miss.
  - Partial write miss: two memory transactions.
- Upstream rules:
  - The master drops cyc in the cycle after ack.
  - cyc sampled in S_ACK is ignored.
  - Back-to-back requests start no earlier than S_IDLE.
- Write-through: memory is always updated before ack, so no dirty state exists and flush needs no writeback.
- Simultaneous events:
  - flush and cyc together in S_IDLE: flush wins, and the request is taken the next cycle.
  - flush outside S_IDLE is ignored; the master must hold it until idle.

Decomposition:
- spi_sram_pkg holds:
  - state_t enum: S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_ACK.
  - CMD-independent constant ADR_W=14.
  - Function byte_merge(sel, new, old).
- One sub-module, spi_sram_cache_tags: valid/tag/data arrays with a registered write port, a combinational read port and a flush-all input. The FSM and merge logic stay in the top module.

Test Plan:
- Reset, then read adr=0x0005 with mem returning 0xDEADBEEF → one mem read, ack with dat_o=0xDEADBEEF. An immediate repeat read gives ack 2 cycles after cyc, with mem_cyc staying 0.
- Write adr=0x0010, sel=F, dat=0x12345678 → one mem write with mem_dat_o=0x12345678. A following read hits and returns 0x12345678 with no mem traffic.
- Partial-write miss: memory holds 0xAABBCCDD at adr=0x0020; write sel=4'b0101, dat=0x11223344 → mem read then mem write of 0xAA22CC44. A later read hit returns 0xAA22CC44.
- Conflict: with LINES=8, read 0x0003 then 0x000B → the second read misses; re-reading 0x0003 misses again and goes to memory.
- Partial-write hit on a cached line 0x00000000, sel=4'b1000, dat=0xFF000000 → no mem read; a single mem write of 0xFF000000.
- Assert flush after caching 0x0005 → the next read of 0x0005 goes to memory. Asserting rst_n=0 during S_MEM_RD → mem_cyc=0 and ack=0 immediately, and no ack is issued afterwards.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: shared types, constants and byte-merge helper for the SPI SRAM cache.
// Revision: 1.0
`default_nettype none

package spi_sram_pkg;

  localparam int ADR_W = 14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  // Byte n of the result comes from new_dat when sel[n] is set, otherwise from old_dat.
  function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                             input logic [31:0] new_dat,
                                             input logic [31:0] old_dat);
    logic [31:0] r;
    r = old_dat;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_dat[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sram_cache_tags.sv
// spi_sram_cache_tags: valid/tag/data line storage, registered write, combinational read.
// Revision: 1.0
`default_nettype none

module spi_sram_cache_tags #(
  parameter int LINES = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

`default_nettype wire

// File: rtl/spi_sram_cache.sv
// spi_sram_cache: direct-mapped write-through word cache between SERV and the SPI SRAM controller.
// Revision: 1.0
`default_nettype none

module spi_sram_cache
  import spi_sram_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cyc,
  input  logic [ADR_W-1:0] adr,
  input  logic             we,
  input  logic [31:0]      dat_i,
  input  logic [3:0]       sel,
  output logic [31:0]      dat_o,
  output logic             ack,
  output logic             mem_cyc,
  output logic [ADR_W-1:0] mem_adr,
  output logic             mem_we,
  output logic [31:0]      mem_dat_o,
  input  logic [31:0]      mem_dat_i,
  input  logic             mem_ack
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADR_W - IDX_W;

  state_t state, state_nx;

  logic [ADR_W-1:0] req_adr;
  logic             req_we;
  logic [31:0]      req_dat;
  logic [3:0]       req_sel;
  logic [31:0]      merged;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic             hit;
  logic             line_we;
  logic [31:0]      line_wdata;
  logic             line_flush;

  assign req_idx    = req_adr[IDX_W-1:0];
  assign req_tag    = req_adr[ADR_W-1:IDX_W];
  assign hit        = line_valid && (line_tag == req_tag);
  assign line_flush = (state == S_IDLE) && flush;

  spi_sram_cache_tags #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (line_flush),
    .rd_idx   (req_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (line_we),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (line_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    line_we    = 1'b0;
    line_wdata = mem_dat_i;
    case (state)
      S_IDLE: begin
        if (!flush && cyc) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!req_we)                         state_nx = hit ? S_ACK : S_MEM_RD;
        else if (req_sel == 4'h0)            state_nx = S_ACK;
        else if (req_sel == 4'hF || hit)     state_nx = S_MEM_WR;
        else                                 state_nx = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_ack) begin
          line_we  = 1'b1;
          state_nx = req_we ? S_MEM_WR : S_ACK;
        end
      end
      S_MEM_WR: begin
        if (mem_ack) begin
          line_we    = 1'b1;
          line_wdata = merged;
          state_nx   = S_ACK;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture, read-data return and the merged write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_adr <= '0;
      req_we  <= 1'b0;
      req_dat <= '0;
      req_sel <= '0;
      merged  <= '0;
      dat_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush && cyc) begin
            req_adr <= adr;
            req_we  <= we;
            req_dat <= dat_i;
            req_sel <= sel;
          end
        end
        S_LOOKUP: begin
          if (!req_we && hit) dat_o  <= line_data;
          if (req_we)         merged <= byte_merge(req_sel, req_dat, line_data);
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            if (req_we) merged <= byte_merge(req_sel, req_dat, mem_dat_i);
            else        dat_o  <= mem_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack       = (state == S_ACK);
  assign mem_cyc   = (state == S_MEM_RD) || (state == S_MEM_WR);
  assign mem_we    = (state == S_MEM_WR);
  assign mem_adr   = req_adr;
  assign mem_dat_o = merged;

endmodule

`default_nettype wire

// File: tb/tb_spi_sram_cache.sv
// tb_spi_sram_cache: randomized and directed checks of spi_sram_cache against a reference model.
// Revision: 1.0
`default_nettype none

module tb_spi_sram_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cyc = 1'b0;
  logic [13:0] adr = '0;
  logic        we = 1'b0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic        mem_cyc;
  logic [13:0] mem_adr;
  logic        mem_we;
  logic [31:0] mem_dat_o;
  logic [31:0] mem_dat_i = '0;
  logic        mem_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_sram_cache #(.LINES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cyc       (cyc),
    .adr       (adr),
    .we        (we),
    .dat_i     (dat_i),
    .sel       (sel),
    .dat_o     (dat_o),
    .ack       (ack),
    .mem_cyc   (mem_cyc),
    .mem_adr   (mem_adr),
    .mem_we    (mem_we),
    .mem_dat_o (mem_dat_o),
    .mem_dat_i (mem_dat_i),
    .mem_ack   (mem_ack)
  );

  function automatic logic [31:0] init_val(input logic [5:0] a);
    return ({26'd0, a} + 32'd1) * 32'h9E37_79B9;
  endfunction

  // ---------------- downstream SRAM device model ----------------
  logic [31:0] dev_mem [64];
  logic [63:0] dev_wr = '0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] last_wdat = '0;
  logic [13:0] last_wadr = '0;
  logic [13:0] last_radr = '0;
  int          wait_cnt = 0;
  int          lat_cfg = -1;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_adr = '0;
  logic [31:0] poke_dat = '0;

  function automatic int next_lat();
    return (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (poke_en) begin
        dev_mem[poke_adr] <= poke_dat;
        dev_wr[poke_adr]  <= 1'b1;
      end
      if (mem_cyc && !mem_ack) begin
        if (wait_cnt == 0) begin
          mem_ack <= 1'b1;
          if (mem_we) begin
            dev_mem[mem_adr[5:0]] <= mem_dat_o;
            dev_wr[mem_adr[5:0]]  <= 1'b1;
            n_wr      <= n_wr + 1;
            last_wdat <= mem_dat_o;
            last_wadr <= mem_adr;
          end else begin
            mem_dat_i <= dev_wr[mem_adr[5:0]] ? dev_mem[mem_adr[5:0]] : init_val(mem_adr[5:0]);
            n_rd      <= n_rd + 1;
            last_radr <= mem_adr;
          end
          wait_cnt <= next_lat();
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end else if (!mem_cyc) begin
        wait_cnt <= next_lat();
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [64];
  logic        m_valid [8];
  logic [10:0] m_tag   [8];
  logic [31:0] exp_rdata, exp_wdat;
  int          exp_nrd, exp_nwr;
  bit          exp_quiet;

  logic [31:0] obs_rdata;
  int          obs_cycles, obs_nrd, obs_nwr;

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void model(input logic w, input logic [13:0] a, input logic [31:0] d,
                                input logic [3:0] s, input bit fl);
    int          i;
    logic        h;
    logic [31:0] m;
    if (fl) model_clear();
    i = int'(a % 14'd8);
    h = m_valid[i] && (m_tag[i] == 11'(a / 14'd8));
    exp_nrd   = 0;
    exp_nwr   = 0;
    exp_wdat  = '0;
    exp_rdata = ref_mem[a[5:0]];
    if (!w) begin
      if (!h) exp_nrd = 1;
    end else if (s != 4'h0) begin
      if (!h && s != 4'hF) exp_nrd = 1;
      m = ref_mem[a[5:0]];
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      ref_mem[a[5:0]] = m;
      exp_wdat = m;
      exp_nwr  = 1;
    end
    if (!w || s != 4'h0) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = 11'(a / 14'd8);
    end
    exp_quiet = (exp_nrd == 0) && (exp_nwr == 0);
  endfunction

  task automatic poke(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_adr = a; poke_dat = d;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_txn(input logic w, input logic [13:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit fl);
    int rd0, wr0, c;
    bit to;
    model(w, a, d, s, fl);
    @(negedge clk);
    rd0 = n_rd; wr0 = n_wr;
    cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s; flush = fl;
    c = 0; to = 1'b0;
    forever begin
      @(posedge clk);
      c++;
      @(negedge clk);
      flush = 1'b0;
      if (ack) break;
      if (c > 300) begin to = 1'b1; break; end
    end
    tests++;
    if (to) begin
      fails++;
      $display("FAIL txn_timeout adr=%h: no ack after %0d cycles, required ack", a, c);
    end
    obs_rdata = dat_o;
    obs_cycles = c;
    cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    obs_nrd = n_rd - rd0;
    obs_nwr = n_wr - wr0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (ack !== 1'b0 || mem_cyc !== 1'b0 || mem_we !== 1'b0 || dat_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b mem_cyc=%b mem_we=%b dat_o=%h, required 0/0/0/0",
               ack, mem_cyc, mem_we, dat_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_adr !== 14'h0 || mem_dat_o !== 32'h0 || ack !== 1'b0 || mem_cyc !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: mem_adr=%h mem_dat_o=%h ack=%b mem_cyc=%b, required all 0",
               mem_adr, mem_dat_o, ack, mem_cyc);
    end
    model_clear();
  endtask

  task automatic test_read_miss_hit();
    poke(6'h05, 32'hDEADBEEF);
    do_txn(1'b0, 14'h0005, 32'h0, 4'hF, 1'b0);
    tests++;
    if (obs_rdata !== 32'hDEADBEEF || obs_nrd != 1 || obs_nwr != 0 || last_radr !== 14'h0005) begin
      fails++;
      $display("FAIL read_miss: dat=%h rd=%0d wr=%0d radr=%h, required DEADBEEF 1 0 0005",
               obs_rdata, obs_nrd, obs_nwr, last_radr);
    end
    do_txn(1'b0, 14'h0005, 32'h0, 4'hF, 1'b0);
    tests++;
    if (obs_rdata !== 32'hDEADBEEF || obs_nrd != 0 || obs_cycles != 2) begin
      fails++;
      $display("FAIL read_hit: dat=%h rd=%0d cycles=%0d, required DEADBEEF 0 2",
               obs_rdata, obs_nrd, obs_cycles);
    end
  endtask

  task automatic test_full_write();
    do_txn(1'b1, 14'h0010, 32'h12345678, 4'hF, 1'b0);
    tests++;
    if (obs_nrd != 0 || obs_nwr != 1 || last_wdat !== 32'h12345678 || last_wadr !== 14'h0010) begin
      fails++;
      $display("FAIL full_write: rd=%0d wr=%0d wdat=%h wadr=%h, required 0 1 12345678 0010",
               obs_nrd, obs_nwr, last_wdat, last_wadr);
    end
    do_txn(1'b0, 14'h0010, 32'h0, 4'hF, 1'b0);
    tests++;
    if (obs_rdata !== 32'h12345678 || obs_nrd != 0 || obs_nwr != 0) begin
      fails++;
      $display("FAIL full_write_readback: dat=%h rd=%0d wr=%0d, required 12345678 0 0",
               obs_rdata, obs_nrd, obs_nwr);
    end
  endtask

  task automatic test_partial_miss();
    poke(6'h20, 32'hAABBCCDD);
    do_txn(1'b1, 14'h0020, 32'h11223344, 4'b0101, 1'b0);
    tests++;
    if (obs_nrd != 1 || obs_nwr != 1 || last_wdat !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL partial_miss: rd=%0d wr=%0d wdat=%h, required 1 1 AA22CC44",
               obs_nrd, obs_nwr, last_wdat);
    end
    do_txn(1'b0, 14'h0020, 32'h0, 4'hF, 1'b0);
    tests++;
    if (obs_rdata !== 32'hAA22CC44 || obs_nrd != 0) begin
      fails++;
      $display("FAIL partial_miss_readback: dat=%h rd=%0d, required AA22CC44 0", obs_rdata, obs_nrd);
    end
  endtask

  task automatic test_conflict();
    do_txn(1'b0, 14'h0003, 32'h0, 4'hF, 1'b0);
    do_txn(1'b0, 14'h000B, 32'h0, 4'hF, 1'b0);
    tests++;
    if (obs_nrd != 1 || obs_rdata !== init_val(6'h0B)) begin
      fails++;
      $display("FAIL conflict_second: rd=%0d dat=%h, required 1 %h", obs_nrd, obs_rdata, init_val(6'h0B));
    end
    do_txn(1'b0, 14'h0003, 32'h0, 4'hF, 1'b0);
    tests++;
    if (obs_nrd != 1 || obs_rdata !== init_val(6'h03)) begin
      fails++;
      $display("FAIL conflict_reread: rd=%0d dat=%h, required 1 %h", obs_nrd, obs_rdata, init_val(6'h03));
    end
  endtask

  task automatic test_partial_hit();
    poke(6'h30, 32'h0);
    do_txn(1'b0, 14'h0030, 32'h0, 4'hF, 1'b0);
    do_txn(1'b1, 14'h0030, 32'hFF000000, 4'b1000, 1'b0);
    tests++;
    if (obs_nrd != 0 || obs_nwr != 1 || last_wdat !== 32'hFF000000) begin
      fails++;
      $display("FAIL partial_hit: rd=%0d wr=%0d wdat=%h, required 0 1 FF000000",
               obs_nrd, obs_nwr, last_wdat);
    end
  endtask

  task automatic test_flush();
    do_txn(1'b0, 14'h0005, 32'h0, 4'hF, 1'b0);
    do_txn(1'b0, 14'h0005, 32'h0, 4'hF, 1'b1);
    tests++;
    if (obs_nrd != 1 || obs_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL flush_miss: rd=%0d dat=%h, required 1 DEADBEEF", obs_nrd, obs_rdata);
    end
  endtask

  task automatic test_random();
    logic        w;
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          fl;
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 14'($urandom_range(0, 63));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 9) == 0);
      do_txn(w, a, d, s, fl);
      tests++;
      if (obs_nrd != exp_nrd || obs_nwr != exp_nwr) begin
        fails++;
        $display("FAIL rand_traffic n=%0d we=%b adr=%h sel=%h: rd=%0d wr=%0d, required %0d %0d",
                 n, w, a, s, obs_nrd, obs_nwr, exp_nrd, exp_nwr);
      end
      if (exp_nwr == 1) begin
        tests++;
        if (last_wdat !== exp_wdat || last_wadr !== a) begin
          fails++;
          $display("FAIL rand_wdata n=%0d adr=%h: wdat=%h wadr=%h, required %h %h",
                   n, a, last_wdat, last_wadr, exp_wdat, a);
        end
      end
      if (!w) begin
        tests++;
        if (obs_rdata !== exp_rdata) begin
          fails++;
          $display("FAIL rand_rdata n=%0d adr=%h: dat=%h, required %h", n, a, obs_rdata, exp_rdata);
        end
      end
      if (exp_quiet) begin
        tests++;
        if (obs_cycles != (fl ? 3 : 2)) begin
          fails++;
          $display("FAIL rand_latency n=%0d adr=%h: cycles=%0d, required %0d",
                   n, a, obs_cycles, fl ? 3 : 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int acks;
    lat_cfg = 8;
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 14'h0027; sel = 4'hF;
    c = 0;
    while (!mem_cyc && c < 20) begin @(negedge clk); c++; end
    tests++;
    if (!mem_cyc) begin
      fails++;
      $display("FAIL reset_mid_start: mem_cyc=%b after %0d cycles, required 1", mem_cyc, c);
    end
    @(negedge clk);
    rst_n = 1'b0;
    cyc = 1'b0;
    #1;
    tests++;
    if (mem_cyc !== 1'b0 || ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_abort: mem_cyc=%b ack=%b, required 0 0", mem_cyc, ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack === 1'b1 || mem_cyc === 1'b1) acks++;
    end
    tests++;
    if (acks != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: ack/mem_cyc seen %0d cycles, required 0", acks);
    end
    lat_cfg = -1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = init_val(6'(i));
      dev_mem[i] = '0;
    end
    model_clear();
    for (int i = 0; i < 8; i++) m_tag[i] = '0;
    test_reset();
    test_read_miss_hit();
    test_full_write();
    test_partial_miss();
    test_conflict();
    test_partial_hit();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
